// File: rtl/regfile_dump_pkg.sv
// Shared constants and FSM encoding for the register-file dump engine.
package regfile_dump_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int NREG_DEF  = 8;
  localparam int IDXW_DEF  = $clog2(NREG_DEF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/regfile_dump_lowest_set.sv
// Priority encoder: index of the lowest set bit of vec, with a flag for an all-zero vector.
module lowest_set #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          none
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end

  assign none = ~|vec;

endmodule

// File: rtl/regfile_dump.sv
// Walks a mask of registers in ascending order, reading each through an external
// read port and presenting it as a valid/ready beat.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREG  = NREG_DEF,
  localparam int IDXW = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [NREG-1:0]  mask,
  output logic [IDXW-1:0]  readnum,
  input  logic [WIDTH-1:0] rf_data,
  output logic [WIDTH-1:0] out_data,
  output logic [IDXW-1:0]  out_num,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  state_t           r_state;
  state_t           w_state_next;
  logic [NREG-1:0]  r_pending;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_out_data;
  logic [IDXW-1:0]  r_out_num;

  logic [NREG-1:0]  w_remaining;
  logic [NREG-1:0]  w_search;
  logic [IDXW-1:0]  w_idx_next;
  logic             w_none;

  // Pending set with the register currently being sent removed.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_remaining
    assign w_remaining[gi] = r_pending[gi] & (r_idx != IDXW'(gi));
  end

  // One encoder serves both the initial pick in IDLE and the follow-on pick in SEND.
  assign w_search = (r_state == ST_IDLE) ? mask : w_remaining;

  lowest_set #(
    .N  (NREG),
    .IW (IDXW)
  ) u_lowest_set (
    .vec  (w_search),
    .idx  (w_idx_next),
    .none (w_none)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_next = w_none ? ST_DONE : ST_READ;
      ST_READ: w_state_next = ST_SEND;
      ST_SEND: if (out_ready) w_state_next = w_none ? ST_DONE : ST_READ;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_pending  <= '0;
      r_idx      <= '0;
      r_out_data <= '0;
      r_out_num  <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (start && !w_none) begin
            r_pending <= mask;
            r_idx     <= w_idx_next;
          end
        end
        ST_READ: begin
          r_out_data <= rf_data;
          r_out_num  <= r_idx;
        end
        ST_SEND: begin
          if (out_ready) begin
            r_pending <= w_remaining;
            if (!w_none) r_idx <= w_idx_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign readnum   = (r_state == ST_READ || r_state == ST_SEND) ? r_idx : '0;
  assign out_data  = r_out_data;
  assign out_num   = r_out_num;
  assign out_valid = (r_state == ST_SEND);
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_regfile_dump.sv
// Randomised bench for regfile_dump against a queue-based model of the expected beat stream.
module tb_regfile_dump;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  mask;
  logic [2:0]  readnum;
  logic [15:0] rf_data;
  logic [15:0] out_data;
  logic [2:0]  out_num;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Register file model: R[i] = 0x1000 + i, combinational in readnum.
  assign rf_data = 16'h1000 + {13'd0, readnum};

  regfile_dump #(.WIDTH(16), .NREG(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mask      (mask),
    .readnum   (readnum),
    .rf_data   (rf_data),
    .out_data  (out_data),
    .out_num   (out_num),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy},      32'd0);
    check({tag, "_done"},  {31'd0, done},      32'd0);
    check({tag, "_data"},  {16'd0, out_data},  32'd0);
    check({tag, "_num"},   {29'd0, out_num},   32'd0);
    check({tag, "_rnum"},  {29'd0, readnum},   32'd0);
  endtask

  // ready_mode: 0 = always ready, 1 = random. stall: ready forced low for the first
  // stall cycles of valid. restart: pulse start with another mask mid-dump.
  // abort_idx: assert reset while that index is being offered (8 = never).
  task automatic run_dump(input logic [7:0] m, input int ready_mode, input int stall,
                          input bit restart, input int abort_idx);
    int  q[$];
    int  c, next_c, done_c, beats;
    bit  rdy, v_exp;
    for (int i = 0; i < 8; i++) if (m[i]) q.push_back(i);
    beats  = 0;
    @(negedge clk);
    start     = 1'b1;
    mask      = m;
    out_ready = 1'b0;
    @(negedge clk);
    start  = 1'b0;
    mask   = 8'($urandom);
    c      = 0;
    next_c = 1;
    done_c = (q.size() == 0) ? 0 : -1;
    forever begin
      if (restart && c == 1) begin
        start = 1'b1;
        mask  = ~m;
      end else begin
        start = 1'b0;
      end
      rdy = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (c < 1 + stall) rdy = 1'b0;
      out_ready = rdy;
      v_exp = (q.size() > 0) && (c >= next_c);
      check("valid", {31'd0, out_valid}, {31'd0, v_exp});
      check("busy",  {31'd0, busy}, {31'd0, (done_c < 0) || (c <= done_c)});
      check("done",  {31'd0, done}, {31'd0, (c == done_c)});
      if (c == done_c) check("readnum_done", {29'd0, readnum}, 32'd0);
      if (v_exp) begin
        check("out_num",  {29'd0, out_num}, q[0]);
        check("out_data", {16'd0, out_data}, 32'h1000 + q[0]);
        check("readnum",  {29'd0, readnum}, q[0]);
        if (q[0] == abort_idx) begin
          reset = 1'b1;
          #1;
          check_idle_outputs("abort");
          @(negedge clk);
          reset = 1'b0;
          out_ready = 1'b0;
          $display("dump mask=%02h aborted by reset at index %0d after %0d beats", m, abort_idx, beats);
          return;
        end
        if (rdy) begin
          void'(q.pop_front());
          beats++;
          next_c = c + 2;
          if (q.size() == 0) done_c = c + 1;
        end
      end
      if (done_c >= 0 && c == done_c + 1) break;
      c++;
      if (c > 400) begin
        check("timeout", 32'd1, 32'd0);
        break;
      end
      @(negedge clk);
    end
    start     = 1'b0;
    out_ready = 1'b0;
    $display("dump mask=%02h ready_mode=%0d stall=%0d restart=%0d beats=%0d cycles=%0d",
             m, ready_mode, stall, restart, beats, c);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    mask      = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    // Start during reset must be ignored.
    start = 1'b1;
    mask  = 8'hFF;
    @(negedge clk);
    check_idle_outputs("reset_start");
    start = 1'b0;
    reset = 1'b0;

    run_dump(8'hFF, 0, 0, 1'b0, 8);         // full sweep, back-to-back
    run_dump(8'b1010_0100, 0, 0, 1'b0, 8);  // sparse mask
    run_dump(8'h01, 0, 5, 1'b0, 8);         // stalled consumer
    run_dump(8'h00, 0, 0, 1'b0, 8);         // empty mask
    run_dump(8'hFF, 0, 0, 1'b0, 3);         // reset mid-dump
    run_dump(8'h80, 0, 0, 1'b0, 8);         // fresh start after reset
    run_dump(8'h5A, 1, 0, 1'b1, 8);         // restart attempt ignored
    run_dump(8'h01, 0, 0, 1'b1, 8);
    for (int t = 0; t < 20; t++) begin
      logic [7:0] rm;
      rm = (t % 7 == 3) ? 8'h00 : 8'($urandom);
      run_dump(rm, 1, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 8);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
